// File: rtl/proc_pkg.sv
// Shared definitions for the execute/write-back slice.
//   - DATA_W / RA_W defaults (must match reg_block)
//   - opcode encodings and instruction field bit positions
//   - sequencer state enum
//   - sext_imm6: sign-extends the 6-bit immediate to DATA_W
// Optional feature macro used by the consumers of this package: EXEC_MUL_EN.
package proc_pkg;

  localparam int DATA_W = 16;
  localparam int RA_W   = 2;
  localparam int INSTR_W = 16;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_MUL  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  function automatic logic [DATA_W-1:0] sext_imm6(input logic signed [5:0] imm);
    logic signed [DATA_W-1:0] ext;
    ext = DATA_W'(imm);
    return ext;
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Instruction handshake plus register-file port bundle for exec_unit.
//   slave  : exec_unit's view (accepts instructions, drives reg_block ports)
//   master : upstream / register-file side
// Signals: instr_valid/instr_ready/instr, rn_1/rn_2 -> rd_1/rd_2 read ports,
// wn/w/wd write port, done/illegal pulses, zero/carry flags.
interface exec_unit_if;
  import proc_pkg::*;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [INSTR_W-1:0]    instr;
  logic [RA_W-1:0]       rn_1;
  logic [RA_W-1:0]       rn_2;
  logic [DATA_W-1:0]     rd_1;
  logic [DATA_W-1:0]     rd_2;
  logic [RA_W-1:0]       wn;
  logic                  w;
  logic [DATA_W-1:0]     wd;
  logic                  done;
  logic                  illegal;
  logic                  zero;
  logic                  carry;

  modport slave (
    input  instr_valid, instr, rd_1, rd_2,
    output instr_ready, rn_1, rn_2, wn, w, wd, done, illegal, zero, carry
  );

  modport master (
    output instr_valid, instr, rd_1, rd_2,
    input  instr_ready, rn_1, rn_2, wn, w, wd, done, illegal, zero, carry
  );

endinterface

// File: rtl/alu16.sv
// Combinational ALU for opcodes 0-8 (ADD, SUB, AND, OR, XOR, SHL, SHR, ADDI, MOV).
//   op     : opcode
//   a, b   : operands (a = rs1, b = rs2)
//   imm6   : immediate for ADDI
//   result : DATA_W result, modulo 2^DATA_W
//   carry  : carry-out (ADD/ADDI), borrow (SUB), 0 otherwise
// Opcodes outside 0-8 produce result 0, carry 0.
module alu16
  import proc_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [5:0]        imm6,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = a << b[3:0];
      OP_SHR: result = a >> b[3:0];
      OP_ADDI: begin
        sum    = {1'b0, a} + {1'b0, sext_imm6(imm6)};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_MOV: result = a;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute/write-back controller in front of reg_block (4 x 16-bit).
// Sequence: IDLE -> READ -> EXEC -> (MUL ->) WB -> IDLE.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : exec_unit_if.slave (instruction handshake, reg_block read/write
//          ports, done/illegal pulses, zero/carry flags)
// Macro EXEC_MUL_EN: when defined, opcode 9 runs a 16-cycle shift-add
// multiplier; when undefined, the multiplier is absent and opcode 9 is illegal.
module exec_unit
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  exec_unit_if.slave bus
);

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [DATA_W-1:0]   res_q;
  logic                carry_q;
  logic                zero_f, carry_f;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic [3:0]          op;
  logic                legal;
  logic                accept;
  logic                ready_c, w_c, done_c, illegal_c;

  function automatic logic is_legal(input logic [3:0] o);
    logic ok;
    case (o)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_ADDI, OP_MOV: ok = 1'b1;
`ifdef EXEC_MUL_EN
      OP_MUL:  ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign op     = instr_q[OP_MSB:OP_LSB];
  assign legal  = is_legal(op);
  assign accept = bus.instr_valid & (state_q == S_IDLE);

  alu16 u_alu (
    .op     (op),
    .a      (op_a),
    .b      (op_b),
    .imm6   (instr_q[IMM_MSB:IMM_LSB]),
    .result (alu_res),
    .carry  (alu_carry)
  );

`ifdef EXEC_MUL_EN
  logic [2*DATA_W-1:0] acc, mcand, acc_nx;
  logic [DATA_W-1:0]   mplier;
  logic [3:0]          mul_cnt;
  logic                mul_last;

  assign acc_nx   = mplier[0] ? acc + mcand : acc;
  assign mul_last = (mul_cnt == 4'd15);

  // MUL datapath: one multiplier bit per cycle, LSB first
  always_ff @(posedge clk) begin
    if (state_q == S_EXEC) begin
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, op_a};
      mplier <= op_b;
    end else if (state_q == S_MUL) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_cnt <= '0;
    end else if (state_q == S_EXEC) begin
      mul_cnt <= '0;
    end else if (state_q == S_MUL) begin
      mul_cnt <= mul_cnt + 4'd1;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    ready_c   = 1'b0;
    w_c       = 1'b0;
    done_c    = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.instr_valid) state_d = S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_WB;
`ifdef EXEC_MUL_EN
        if (op == OP_MUL) state_d = S_MUL;
`endif
      end
      S_MUL: begin
`ifdef EXEC_MUL_EN
        if (mul_last) state_d = S_WB;
`else
        state_d = S_IDLE;
`endif
      end
      S_WB: begin
        done_c    = 1'b1;
        w_c       = legal;
        illegal_c = ~legal;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: sequencer, latched instruction, result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_f  <= 1'b0;
      carry_f <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= bus.instr;
      if (state_q == S_EXEC) begin
        res_q   <= alu_res;
        carry_q <= alu_carry;
      end
`ifdef EXEC_MUL_EN
      if ((state_q == S_MUL) && mul_last) begin
        res_q   <= acc_nx[DATA_W-1:0];
        carry_q <= |acc_nx[2*DATA_W-1:DATA_W];
      end
`endif
      if ((state_q == S_WB) && legal) begin
        zero_f  <= (res_q == '0);
        carry_f <= carry_q;
      end
    end
  end

  // READ -> EXEC boundary: operand capture from reg_block
  always_ff @(posedge clk) begin
    if (state_q == S_READ) begin
      op_a <= bus.rd_1;
      op_b <= bus.rd_2;
    end
  end

  assign bus.instr_ready = ready_c;
  assign bus.rn_1        = instr_q[RS1_MSB:RS1_LSB];
  assign bus.rn_2        = instr_q[RS2_MSB:RS2_LSB];
  assign bus.wn          = instr_q[RD_MSB:RD_LSB];
  assign bus.wd          = res_q;
  assign bus.w           = w_c;
  assign bus.done        = done_c;
  assign bus.illegal     = illegal_c;
  assign bus.zero        = zero_f;
  assign bus.carry       = carry_f;

endmodule

// File: doc/exec_unit.md
# exec_unit

Multi-cycle execute/write-back controller that sits directly upstream of `reg_block`, the 4×16-bit register file. It accepts one 16-bit instruction word over a valid/ready handshake and drives `reg_block`'s read ports (`rn_1`, `rn_2`). It latches the returned operands (`rd_1`, `rd_2`), computes a result and writes it back through `wn`/`w`/`wd`. It also maintains zero/carry flags and signals completion and illegal opcodes.

## Interface
- `DATA_W`, 16, operand/result width; must match `reg_block`
- `RA_W`, 2, register address width (4 registers)
- `clk` in 1: single clock; all state changes on the rising edge
- `rst` in 1: reset is asynchronous and active-high
- `instr_valid` in 1: upstream presents `instr`
- `instr_ready` out 1: block can accept; high only in IDLE
- `instr` in 16: fields `[15:12]` op, `[11:10]` rd, `[9:8]` rs1, `[7:6]` rs2, `[5:0]` imm6
- `rn_1`, `rn_2` out RA_W: read addresses to `reg_block`
- `rd_1`, `rd_2` in DATA_W: read data from `reg_block`, combinational w.r.t. `rn_*`
- `wn` out RA_W: write address
- `w` out 1: write enable; `reg_block` writes on the `clk` edge
- `wd` out DATA_W: write data
- `done` out 1: one-cycle pulse, instruction retired
- `illegal` out 1: one-cycle pulse with `done`, opcode undefined, no write
- `zero`, `carry` out 1: flags from the last legal instruction

## Operation
- **Opcodes:**
  - 0 ADD: carry = carry-out
  - 1 SUB: carry = borrow, i.e. a<b unsigned
  - 2 AND, 3 OR, 4 XOR, 8 MOV (result=a): carry=0
  - 5 SHL, 6 SHR: shift a by b[3:0], logical; carry=0
  - 7 ADDI: a + sign-extended imm6; carry = carry-out
  - 9 MUL: low 16 bits of a*b; carry = OR of the high 16 bits
  - All others illegal.
- **Operand mapping:** a = register rs1, b = register rs2.
- **Zero flag:** zero = (result == 0).
- **Arithmetic:** all arithmetic is modulo 2^16.
- **States:** IDLE → READ → EXEC → (MUL →) WB → IDLE.
- **IDLE:** `instr_ready`=1. On `instr_valid`&`instr_ready`, latch `instr` and go to READ.
- **READ:** drive `rn_1`=rs1 and `rn_2`=rs2. At the edge, capture `rd_1`/`rd_2` into op_a/op_b and go to EXEC.
- **EXEC:**
  - Compute the result into a result register.
  - MUL (when compiled in) goes to MUL; all other opcodes go to WB.
- **MUL:** 16-cycle shift-add over op_b bits, LSB first, with a 32-bit accumulator, then WB.
- **WB:**
  - Legal opcode: `w`=1, `wn`=rd, `wd`=result, `done`=1; flags update at the edge leaving WB.
  - Illegal opcode: `w`=0, `done`=1, `illegal`=1; flags hold.
- **Output hold:** `rn_1`/`rn_2` hold the latched fields from READ through WB. In IDLE they hold their last values (0 after reset).
- **Self-reference:** rd may equal rs1/rs2. Operands are captured before write-back, so this is safe.
- **Back-pressure:** `instr_valid` while not IDLE is ignored (not latched). Upstream must hold `instr` until it sees `instr_ready`.

## Timing
- **Reset values:** state=IDLE, `instr_ready`=1, `rn_1`=`rn_2`=`wn`=0, `wd`=0, `w`=`done`=`illegal`=0, `zero`=`carry`=0.
- **Latency:** instruction accepted at edge N. `w`/`done` are high in the cycle after edge N+2. The register file is updated at edge N+3, and the block is back in IDLE.
- **Throughput:** one instruction per 4 cycles; MUL takes 20 cycles.
- **Output source:** `w`, `done` and `illegal` are decoded from the state register only. Asserting `rst` mid-instruction drops them immediately (asynchronously) and abandons the instruction with no partial write. Flags return to 0.
- **Next accept:** `instr_ready` rises in the cycle after WB. An instruction presented then is accepted at the next edge; no bubble beyond IDLE.

## Configuration
- **`EXEC_MUL_EN` defined:** opcode 9 executes via the MUL state as described.
- **`EXEC_MUL_EN` undefined:** the MUL state and multiplier datapath are removed, and opcode 9 is illegal.

## Structure
- **Shared package `proc_pkg`:**
  - opcode localparams
  - instruction field bit positions
  - state enum (IDLE, READ, EXEC, MUL, WB)
  - `DATA_W`/`RA_W` defaults
- **Sub-module `alu16`:** one natural combinational sub-module covering ops 0–8, with outputs result/carry. The sequencer, multiplier and flags stay in `exec_unit`.

## Test plan
- **ADD:** R1=5, R2=7; ADD rd=3, rs1=1, rs2=2 → `w` with `wn`=3, `wd`=12 four cycles after accept; `zero`=0, `carry`=0.
- **SUB borrow:** R1=0, R2=1; SUB rd=0 → `wd`=16'hFFFF, `carry`=1, `zero`=0. Then XOR rd=0, rs1=1, rs2=1 → `wd`=0, `zero`=1, `carry`=0.
- **ADDI:** R2=3; ADDI rd=2, rs1=2, imm6=6'h3E (−2) → `wd`=1. SHL of 16'h8001 by 1 → `wd`=16'h0002.
- **MUL:** with `EXEC_MUL_EN`, R1=300, R2=300 → `wd`=16'h5F90, `carry`=1, `done` 20 cycles after accept. Without the macro → `illegal`=1, `w`=0, register unchanged.
- **Back-pressure and illegal:** `instr_valid` held through a busy instruction → second instruction accepted only when `instr_ready`=1. Opcode 15 → `done`=`illegal`=1, flags unchanged.
- **Reset mid-operation:** assert `rst` during EXEC → `w`/`done` never pulse, state=IDLE, `instr_ready`=1, registers unchanged.
